// File: rtl/xor_par_pkg.sv
// xor_par_pkg
//   Shared constants and elaboration-time helpers for the xor_par parity tree.
//   XOR_PAR_MAX_WIDTH : largest supported data width
//   tree_depth()      : ceil(log2(width)), number of XOR levels in the tree
//   level_count()     : number of operands present at a given tree level
package xor_par_pkg;

   localparam int XOR_PAR_MAX_WIDTH = 64;

   // ceil(log2(width)); a single-bit word needs no XOR levels.
   function automatic int tree_depth(input int width);
      int depth;
      depth = 0;
      for (int i = 0; i < 7; i++) begin
         if ((32'sd1 << i) < width) begin
            depth = i + 1;
         end else begin
            depth = depth;
         end
      end
      return depth;
   endfunction

   // Operands at level lvl: each level halves the count, rounding up so an
   // odd leftover operand is carried to the next level unchanged.
   function automatic int level_count(input int width, input int lvl);
      return (width + (32'sd1 << lvl) - 32'sd1) >>> lvl;
   endfunction

endpackage

// File: rtl/xor_par_xor2_cell.sv
// xor2_cell
//   One 2-input XOR node of the parity tree. Kept as its own module so every
//   tree node is a distinct instance in the netlist.
//   x, y : operand bits
//   z    : x ^ y
module xor2_cell (
   input  logic x,
   input  logic y,
   output logic z
);

   assign z = x ^ y;

endmodule

// File: rtl/xor_par.sv
// xor_par
//   Parity generator for a WIDTH-bit word built as a balanced tree of
//   2-input XOR cells (WIDTH-1 cells, ceil(log2(WIDTH)) levels).
//   Parameters:
//     WIDTH : data width, 1..XOR_PAR_MAX_WIDTH
//     ODD   : 0 = even parity, 1 = odd parity (inverted XOR)
//   Ports:
//     clk      : rising-edge clock for parity_q
//     rst      : asynchronous active-high reset, forces parity_q to ODD
//     a        : data word
//     parity   : combinational parity of a (independent of clk/rst)
//     parity_q : parity registered on clk
module xor_par
   import xor_par_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit ODD   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   output logic             parity,
   output logic             parity_q
);

   localparam int DEPTH = tree_depth(WIDTH);

   // Each level lives in its own generate scope so levels are separate
   // vectors; level 0 is the input word, level DEPTH holds the single root.
   for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
      localparam int CNT = level_count(WIDTH, l);
      logic [CNT-1:0] lvl_s;

      if (l == 0) begin : g_leaf
         assign lvl_s = a;
      end else begin : g_node
         localparam int PREV = level_count(WIDTH, l - 1);
         for (genvar j = 0; j < CNT; j++) begin : g_j
            if ((2 * j + 1) < PREV) begin : g_xor
               xor2_cell u_xor (
                  .x (g_lvl[l-1].lvl_s[2*j]),
                  .y (g_lvl[l-1].lvl_s[2*j+1]),
                  .z (lvl_s[j])
               );
            end else begin : g_pass
               // Odd leftover operand rides up to the next level untouched.
               assign lvl_s[j] = g_lvl[l-1].lvl_s[2*j];
            end
         end
      end
   end

   assign parity = g_lvl[DEPTH].lvl_s[0] ^ ODD;

   // Output register; reset value ODD is the parity of the all-zero word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= ODD;
      end else begin
         parity_q <= parity;
      end
   end

endmodule

// File: tb/tb_xor_par.sv
// tb_xor_par
//   Scoreboard bench for xor_par: stimulus pushes expected bits into a queue,
//   a monitor process pops each entry and compares it with the selected output.
module tb_xor_par;

   localparam logic [3:0] CH_P8E = 4'd0;  // W8 even, parity
   localparam logic [3:0] CH_P8O = 4'd1;  // W8 odd,  parity
   localparam logic [3:0] CH_P8R = 4'd2;  // W8 even (clocked), parity
   localparam logic [3:0] CH_Q8R = 4'd3;  // W8 even (clocked), parity_q
   localparam logic [3:0] CH_Q8O = 4'd4;  // W8 odd  (clocked), parity_q
   localparam logic [3:0] CH_P1  = 4'd5;
   localparam logic [3:0] CH_P5  = 4'd6;
   localparam logic [3:0] CH_P64 = 4'd7;

   typedef struct packed {
      logic [3:0]  chan;
      logic        exp;
      logic [63:0] stim;
   } sb_item_t;

   sb_item_t sb_q[$];
   int push_cnt = 0;
   int pop_cnt  = 0;
   int n_checks = 0;
   int n_fail   = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clk_x = 1'bx;
   logic        rst_x = 1'bx;
   logic [7:0]  a8e = 8'h00;
   logic [7:0]  a8r = 8'h00;
   logic [0:0]  a1  = 1'b0;
   logic [4:0]  a5  = 5'b00000;
   logic [63:0] a64 = 64'h0;

   logic p8e, q8e, p8r, q8r, p8o, q8o, p1, q1, p5, q5, p64, q64;

   always #5 clk = ~clk;

   xor_par #(.WIDTH(8), .ODD(1'b0)) u_w8e (
      .clk(clk_x), .rst(rst_x), .a(a8e), .parity(p8e), .parity_q(q8e));
   xor_par #(.WIDTH(8), .ODD(1'b0)) u_w8r (
      .clk(clk), .rst(rst), .a(a8r), .parity(p8r), .parity_q(q8r));
   xor_par #(.WIDTH(8), .ODD(1'b1)) u_w8o (
      .clk(clk), .rst(rst), .a(a8r), .parity(p8o), .parity_q(q8o));
   xor_par #(.WIDTH(1), .ODD(1'b0)) u_w1 (
      .clk(clk_x), .rst(rst_x), .a(a1), .parity(p1), .parity_q(q1));
   xor_par #(.WIDTH(5), .ODD(1'b0)) u_w5 (
      .clk(clk_x), .rst(rst_x), .a(a5), .parity(p5), .parity_q(q5));
   xor_par #(.WIDTH(64), .ODD(1'b0)) u_w64 (
      .clk(clk_x), .rst(rst_x), .a(a64), .parity(p64), .parity_q(q64));

   function automatic string chan_name(input logic [3:0] ch);
      case (ch)
         CH_P8E:  return "w8_even_parity";
         CH_P8O:  return "w8_odd_parity";
         CH_P8R:  return "w8_clk_parity";
         CH_Q8R:  return "w8_even_parity_q";
         CH_Q8O:  return "w8_odd_parity_q";
         CH_P1:   return "w1_parity";
         CH_P5:   return "w5_parity";
         CH_P64:  return "w64_parity";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic chan_value(input logic [3:0] ch);
      case (ch)
         CH_P8E:  return p8e;
         CH_P8O:  return p8o;
         CH_P8R:  return p8r;
         CH_Q8R:  return q8r;
         CH_Q8O:  return q8o;
         CH_P1:   return p1;
         CH_P5:   return p5;
         CH_P64:  return p64;
         default: return 1'bx;
      endcase
   endfunction

   // Independent reference: parity from a population count.
   function automatic logic ref_parity(input logic [63:0] v);
      return logic'($countones(v) % 2);
   endfunction

   // Queue an expectation, then give the monitor a time step to consume it
   // before the stimulus moves on.
   task automatic expect_bit(input logic [3:0] ch, input logic exp, input logic [63:0] stim);
      sb_item_t it;
      it.chan = ch;
      it.exp  = exp;
      it.stim = stim;
      sb_q.push_back(it);
      push_cnt++;
      #1;
   endtask

   // Monitor: pop each expectation and compare with the live DUT output.
   initial begin
      sb_item_t it;
      logic     act;
      forever begin
         wait (push_cnt != pop_cnt);
         it = sb_q.pop_front();
         pop_cnt++;
         act = chan_value(it.chan);
         n_checks++;
         if (act !== it.exp) begin
            n_fail++;
            $display("FAIL %s stim=0x%0h actual=%b required=%b at t=%0t",
                     chan_name(it.chan), it.stim, act, it.exp, $time);
         end
      end
   end

   // Watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   typedef struct packed {
      logic [7:0] a;
      logic       even;
   } vec8_t;

   initial begin
      vec8_t v8 [5];
      v8[0] = '{8'h00, 1'b0};
      v8[1] = '{8'h01, 1'b1};
      v8[2] = '{8'h03, 1'b0};
      v8[3] = '{8'h7F, 1'b1};
      v8[4] = '{8'hFF, 1'b0};

      // Directed W8 even vectors (hand-computed).
      for (int i = 0; i < 5; i++) begin
         a8e = v8[i].a;
         #20;
         expect_bit(CH_P8E, v8[i].even, {56'h0, v8[i].a});
      end

      // Exhaustive W8 even sweep, clk/rst of that instance left X.
      for (int v = 0; v < 256; v++) begin
         a8e = 8'(v);
         #20;
         expect_bit(CH_P8E, ref_parity({56'h0, 8'(v)}), 64'(v));
      end

      // W8 odd parity, combinational.
      a8r = 8'h00; #5; expect_bit(CH_P8O, 1'b1, 64'h00);
      a8r = 8'h01; #5; expect_bit(CH_P8O, 1'b0, 64'h01);
      a8r = 8'hFF; #5; expect_bit(CH_P8O, 1'b1, 64'hFF);

      // Width corners.
      a1 = 1'b1; #5; expect_bit(CH_P1, 1'b1, 64'h1);
      a1 = 1'b0; #5; expect_bit(CH_P1, 1'b0, 64'h0);
      a5 = 5'b10101; #5; expect_bit(CH_P5, 1'b1, 64'h15);
      a5 = 5'b11011; #5; expect_bit(CH_P5, 1'b0, 64'h1B);
      a5 = 5'b11111; #5; expect_bit(CH_P5, 1'b1, 64'h1F);
      a64 = {64{1'b1}}; #5; expect_bit(CH_P64, 1'b0, a64);
      a64 = 64'h1 << 63; #5; expect_bit(CH_P64, 1'b1, a64);
      a64 = 64'h8000_0000_0000_0001; #5; expect_bit(CH_P64, 1'b0, a64);

      // Registered path: get a known 1 into parity_q before any reset.
      @(negedge clk);
      a8r = 8'h01;
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b1, 64'h01);
      expect_bit(CH_Q8O, 1'b0, 64'h01);

      // Async reset between edges.
      rst = 1'b1;
      #1;
      expect_bit(CH_Q8R, 1'b0, 64'h01);
      expect_bit(CH_Q8O, 1'b1, 64'h01);
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b0, 64'h01);
      expect_bit(CH_P8R, 1'b1, 64'h01);

      // Release, a=0x01 then a=0x03.
      rst = 1'b0;
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b1, 64'h01);
      expect_bit(CH_Q8O, 1'b0, 64'h01);
      a8r = 8'h03;
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b0, 64'h03);
      expect_bit(CH_Q8O, 1'b1, 64'h03);

      // Reset mid-stream with parity_q = 1, held across two edges.
      a8r = 8'h01;
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b1, 64'h01);
      #1 rst = 1'b1;
      #1;
      expect_bit(CH_Q8R, 1'b0, 64'h01);
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b0, 64'h01);
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b0, 64'h01);
      expect_bit(CH_Q8O, 1'b1, 64'h01);
      rst = 1'b0;
      @(negedge clk);
      expect_bit(CH_Q8R, 1'b1, 64'h01);

      #2;
      if (push_cnt != pop_cnt) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", push_cnt - pop_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xor_par.md
# xor_par

Parity generator for an N-bit word (default 8), built as a balanced tree of 2-input XOR gates. It provides a combinational parity bit for immediate use and a registered copy for pipelined consumers. The block sits as a leaf in datapaths, e.g. bus-protection generators and checkers, and serves as a gate-level reference circuit.

## Interface
- `WIDTH`, default 8: data width in bits; legal values are 1..64.
- `ODD`, default 0: parity sense. 0 = even parity (XOR of all bits); 1 = odd parity (inverted XOR).
- `clk` input, 1 bit: single clock, rising-edge active.
- `rst` input, 1 bit: reset; asynchronous, active-high.
- `a` input, WIDTH bits: data word.
- `parity` output, 1 bit: combinational parity of `a`.
- `parity_q` output, 1 bit: `parity` registered on `clk`.

## Operation
- `parity` = a[0] ^ a[1] ^ … ^ a[WIDTH-1], then ^ ODD.
- `parity` is purely combinational. It must not depend on `clk` or `rst`, and must be correct even when `clk`/`rst` are left unconnected or X.
- The XOR reduction is a balanced binary tree of 2-input XORs:
  - depth = ceil(log2(WIDTH)).
  - Odd leftover operands pass to the next level unchanged.
  - No reduction operator; the tree is built explicitly with generate loops.
- WIDTH = 1: `parity` = a[0] ^ ODD (no XOR gates).
- All 2^WIDTH input values are legal; there are no invalid or X-propagation special cases beyond standard gate semantics.
- `parity_q` is a single flip-flop fed by `parity`.

## Timing
- `parity`: zero cycles latency; settles within combinational delay after any change on `a`.
- `parity_q`: one cycle latency. It samples `parity` on each rising `clk` and presents it after that edge.
- Reset:
  - `rst` = 1 forces `parity_q` to ODD immediately, independent of `clk`. This is the parity of the all-zero word.
  - `parity_q` is held at ODD while `rst` is high.
  - `parity` is unaffected by `rst`.
- First rising `clk` after `rst` deasserts loads the current `parity`.
- Reset asserted mid-operation: `parity_q` jumps to ODD asynchronously; no partial or glitch state is retained.
- `a` changing in the same cycle as a clock edge: `parity_q` captures the value settled before the edge (normal setup).

## Structure
- Shared package `xor_par_pkg`: constant `XOR_PAR_MAX_WIDTH = 64` and function `tree_depth(width)`, returning ceil(log2).
- One sub-module `xor2_cell` (2-input XOR, 1-bit in/out). It is instantiated per tree node so gate count is visible to synthesis and CGP flows.
  - Gate count for WIDTH inputs: WIDTH−1 XOR cells.
  - WIDTH = 8: 7 cells, depth 3.
- Top `xor_par` contains:
  - the generate-built tree,
  - the ODD inversion,
  - the output register.

## Test plan
- Exhaustive combinational check, WIDTH = 8, ODD = 0:
  - Sweep a = 0..255, holding each value 20 time units.
  - `parity` === XOR of all bits (e.g. 0x00→0, 0x01→1, 0x03→0, 0x7F→1, 0xFF→0).
  - `clk`/`rst` unconnected throughout.
- ODD = 1, WIDTH = 8: a = 0x00 → `parity` = 1; a = 0x01 → 0; a = 0xFF → 1.
- Registered path:
  - Assert `rst` → `parity_q` = ODD without a clock edge.
  - Release `rst`, drive a = 0x01, one rising edge → `parity_q` = 1.
  - Then a = 0x03, next edge → `parity_q` = 0.
- Reset mid-stream: `parity_q` = 1, assert `rst` between edges → `parity_q` drops to 0 immediately and stays 0 across edges until release.
- Width corners:
  - WIDTH = 1: a = 1 → `parity` = 1.
  - WIDTH = 5 (odd leftover): a = 5'b10101 → 1, 5'b11011 → 0.
  - WIDTH = 64: a = all-ones → 0, a = 1<<63 → 1.
